// File: rtl/load_align_unit.sv
// Load path: word-aligned bus read via req/ack, then byte/half/word extraction with sign/zero extension.
// Latency: 2 cycles minimum for a bus access, 1 cycle for misaligned or op==00; result held until resp_ready.
module load_align_unit #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic        req_signed,
    output logic        bus_rd,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        adel,
    output logic        bus_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      op_q, op_d;
    logic            sgn_q, sgn_d;
    logic            bus_rd_q, bus_rd_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     data_q, data_d;
    logic            adel_q, adel_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            misaligned;

    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [1:0] op, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            2'b01:   r = {{24{sgn & b[7]}}, b};
            2'b10:   r = {{16{sgn & h[15]}}, h};
            2'b11:   r = rd;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign misaligned = (req_op == 2'b10 && req_addr[0]) ||
                        (req_op == 2'b11 && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        op_d       = op_q;
        sgn_d      = sgn_q;
        bus_rd_d   = bus_rd_q;
        bus_addr_d = bus_addr_q;
        data_d     = data_q;
        adel_d     = adel_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d = req_addr[1:0];
                    op_d  = req_op;
                    sgn_d = req_signed;
                    if (req_op == 2'b00) begin
                        data_d  = 32'd0;
                        state_d = ST_DONE;
                    end else if (misaligned) begin
                        data_d  = 32'd0;
                        adel_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        bus_rd_d   = 1'b1;
                        bus_addr_d = {req_addr[31:2], 2'b00};
                        cnt_d      = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // ack takes priority over an expiring timeout in the same cycle
                if (bus_ack) begin
                    data_d   = extract(bus_rdata, off_q, op_q, sgn_q);
                    bus_rd_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d   = 32'd0;
                    bus_rd_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    adel_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            off_q      <= 2'b00;
            op_q       <= 2'b00;
            sgn_q      <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= 32'd0;
            data_q     <= 32'd0;
            adel_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            op_q       <= op_d;
            sgn_q      <= sgn_d;
            bus_rd_q   <= bus_rd_d;
            bus_addr_q <= bus_addr_d;
            data_q     <= data_d;
            adel_q     <= adel_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign bus_rd     = bus_rd_q;
    assign bus_addr   = bus_addr_q;
    assign resp_data  = data_q;
    assign adel       = adel_q;
    assign bus_err    = err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit with a transaction-level expectation queue checked every cycle.
module tb_load_align_unit;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic        req_signed;
    logic        bus_rd;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        adel;
    logic        bus_err;

    load_align_unit #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_signed(req_signed),
        .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .adel(adel), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        adel;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic [31:0] exp_baddr = 32'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rules written as plain shifts and masks.
    function automatic logic [31:0] model_load(input logic [1:0] op, input logic [31:0] addr,
                                               input logic sgn, input logic [31:0] rdata);
        logic [31:0] v;
        case (op)
            2'b01: begin
                v = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b10: begin
                v = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            2'b11:   v = rdata;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic model_mis(input logic [1:0] op, input logic [31:0] addr);
        return (op == 2'b10 && addr % 2 != 0) || (op == 2'b11 && addr % 4 != 0);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_rd) begin
                tests++;
                if (bus_addr !== exp_baddr) begin
                    fails++;
                    $display("FAIL cmp_bus_addr: got 0x%08h expected 0x%08h", bus_addr, exp_baddr);
                end
            end
            if (resp_valid) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL cmp_unexpected_resp: data 0x%08h with no outstanding load", resp_data);
                end else begin
                    cur = expq[0];
                    if (resp_data !== cur.data || adel !== cur.adel || bus_err !== cur.err) begin
                        fails++;
                        $display("FAIL cmp_resp: got data 0x%08h adel %0b err %0b expected data 0x%08h adel %0b err %0b",
                                 resp_data, adel, bus_err, cur.data, cur.adel, cur.err);
                    end
                    if (resp_ready) void'(expq.pop_front());
                end
            end else begin
                tests++;
                if (adel !== 1'b0 || bus_err !== 1'b0) begin
                    fails++;
                    $display("FAIL cmp_flags_idle: adel %0b err %0b expected 0 0", adel, bus_err);
                end
            end
        end
    end

    // Issue one load, drive the bus, hold the response, then release it.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] op, input logic sgn,
                           input int ack_at, input logic [31:0] rdata, input int hold,
                           input logic [31:0] lit_data, input logic lit_adel, input logic lit_err,
                           input int lit_nrd, input int lit_lat);
        exp_t e;
        logic fault;
        int   nrd;
        int   lat;
        fault  = model_mis(op, addr) || op == 2'b00;
        e.adel = model_mis(op, addr);
        e.err  = !fault && (ack_at < 0 || ack_at >= TIMEOUT);
        e.data = (fault || e.err) ? 32'd0 : model_load(op, addr, sgn, rdata);
        expq.push_back(e);
        if (!fault) exp_baddr = addr & 32'hFFFF_FFFC;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_op     = op;
        req_signed = sgn;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        nrd = 0;
        lat = -1;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            bus_ack   = (k == ack_at);
            bus_rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            if (bus_rd) nrd++;
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles of addr 0x%08h", TIMEOUT + 4, addr);
        end
        check("bus_rd_cycles", nrd, lit_nrd);
        check("resp_latency", lat, lit_lat);
        check("resp_data_lit", resp_data, lit_data);
        check("adel_lit", {31'd0, adel}, {31'd0, lit_adel});
        check("bus_err_lit", {31'd0, bus_err}, {31'd0, lit_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_op    = 2'b11;
            req_addr  = 32'h0000_0100;
            check("req_ready_busy", {31'd0, req_ready}, 32'd0);
            check("resp_valid_held", {31'd0, resp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_cleared", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_op     = 2'b00;
        req_signed = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'd0;
        resp_ready = 1'b0;

        check("model_lb", model_load(2'b01, 32'h1003, 1'b1, 32'h8012_3456), 32'hFFFF_FF80);
        check("model_lhu", model_load(2'b10, 32'h2002, 1'b0, 32'hBEEF_1234), 32'h0000_BEEF);
        check("model_lh_lo", model_load(2'b10, 32'h6000, 1'b1, 32'h1234_8001), 32'hFFFF_8001);
        check("model_lbu_b1", model_load(2'b01, 32'h8001, 1'b0, 32'h0000_A500), 32'h0000_00A5);

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_bus_rd", {31'd0, bus_rd}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_flags", {30'd0, adel, bus_err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_load(32'h1003, 2'b01, 1'b1, 0, 32'h8012_3456, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 1);
        check("bus_addr_hold", bus_addr, 32'h0000_1000);
        do_load(32'h2002, 2'b10, 1'b0, 3, 32'hBEEF_1234, 0, 32'h0000_BEEF, 1'b0, 1'b0, 4, 4);
        do_load(32'h3001, 2'b11, 1'b0, -1, 32'h0, 0, 32'h0, 1'b1, 1'b0, 0, 0);
        do_load(32'h3003, 2'b10, 1'b1, -1, 32'h0, 0, 32'h0, 1'b1, 1'b0, 0, 0);
        do_load(32'h3004, 2'b11, 1'b0, 1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 2);
        do_load(32'h5001, 2'b01, 1'b0, -1, 32'h0, 0, 32'h0, 1'b0, 1'b1, 4, 4);
        do_load(32'h5002, 2'b01, 1'b1, 3, 32'h00FF_0000, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 4);
        do_load(32'h6000, 2'b10, 1'b1, 0, 32'h1234_8001, 5, 32'hFFFF_8001, 1'b0, 1'b0, 1, 1);
        do_load(32'h7000, 2'b00, 1'b1, -1, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0, 0);
        do_load(32'h8001, 2'b01, 1'b0, 2, 32'h0000_A500, 0, 32'h0000_00A5, 1'b0, 1'b0, 3, 3);
        do_load(32'h8002, 2'b10, 1'b1, 0, 32'h7FFF_0000, 0, 32'h0000_7FFF, 1'b0, 1'b0, 1, 1);
        do_load(32'h9000, 2'b11, 1'b1, 1, 32'h8000_0001, 1, 32'h8000_0001, 1'b0, 1'b0, 2, 2);

        // Reset in the middle of a bus wait must drop the access and any response.
        req_valid  = 1'b1;
        req_addr   = 32'h0000_4000;
        req_op     = 2'b01;
        req_signed = 1'b0;
        exp_baddr  = 32'h0000_4000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        @(posedge clk); #1;
        check("wait_bus_rd", {31'd0, bus_rd}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_bus_rd", {31'd0, bus_rd}, 32'd0);
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1;
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_no_resp", {31'd0, resp_valid}, 32'd0);
            check("late_ack_no_rd", {31'd0, bus_rd}, 32'd0);
        end
        @(posedge clk); #1;
        do_load(32'h1001, 2'b01, 1'b1, 0, 32'h0000_7F00, 0, 32'h0000_007F, 1'b0, 1'b0, 1, 1);

        check("expq_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
